// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: stage hazard information in, stage register controls out.
// master = pipeline datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] id_rs_addr;
   logic [REG_ADDR_W-1:0] id_rt_addr;
   logic [1:0]            id_rs_tuse;
   logic [1:0]            id_rt_tuse;
   logic                  id_is_md;
   logic [REG_ADDR_W-1:0] ex_wr_addr;
   logic [1:0]            ex_tnew;
   logic [REG_ADDR_W-1:0] mem_wr_addr;
   logic [1:0]            mem_tnew;
   logic                  ex_md_start;
   logic                  ex_md_is_div;
   logic                  mem_req;
   logic                  mem_ack;
   logic                  flush_req;

   logic                  pc_en;
   logic                  if_id_en;
   logic                  id_ex_en;
   logic                  ex_mem_en;
   logic                  mem_wb_en;
   logic                  if_id_clr;
   logic                  id_ex_clr;
   logic                  ex_mem_clr;
   logic                  mem_wb_clr;
   logic                  md_busy;

   modport master (
      output id_rs_addr, id_rt_addr, id_rs_tuse, id_rt_tuse, id_is_md,
             ex_wr_addr, ex_tnew, mem_wr_addr, mem_tnew,
             ex_md_start, ex_md_is_div, mem_req, mem_ack, flush_req,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, md_busy
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_rs_tuse, id_rt_tuse, id_is_md,
             ex_wr_addr, ex_tnew, mem_wr_addr, mem_tnew,
             ex_md_start, ex_md_is_div, mem_req, mem_ack, flush_req,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, md_busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer. Arbitrates memory wait states,
// redirect flushes, data hazards and MDU occupancy into per-stage enable/clear
// controls. Decisions are combinational from registered state plus inputs.
// Optional: define HAZ_PERF_CNT_EN to add stall_cycles / flush_count counters.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                clk,
   input  logic                reset,
   pipe_hazard_ctrl_if.slave   hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]         stall_cycles,
   output logic [31:0]         flush_count
`endif
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   typedef enum logic [2:0] {
      MODE_RESET,
      MODE_MEM_WAIT,
      MODE_FLUSH,
      MODE_STALL,
      MODE_RUN
   } mode_e;

   mode_e            mode;
   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] md_cnt_nxt;
   logic             flush_pend;
   logic             flush_pend_nxt;
   logic             md_busy_int;
   logic             data_stall;
   logic             md_stall;
   logic             mem_stall;
   logic             flush_any;
   logic             pc_en_int;
   logic             ex_mem_en_int;

   // RAW hit: producer writes a nonzero register the consumer reads, too late to forward.
   function automatic logic raw_hit(input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] dst,
                                    input logic [1:0]            tnew,
                                    input logic [1:0]            tuse);
      return (src != REG_ADDR_W'(0)) && (src == dst) && (tnew > tuse);
   endfunction

   // Hazard cause detection.
   always_comb begin
      md_busy_int = (md_cnt != CNT_W'(0));
      data_stall  = raw_hit(hz.id_rs_addr, hz.ex_wr_addr,  hz.ex_tnew,  hz.id_rs_tuse) |
                    raw_hit(hz.id_rs_addr, hz.mem_wr_addr, hz.mem_tnew, hz.id_rs_tuse) |
                    raw_hit(hz.id_rt_addr, hz.ex_wr_addr,  hz.ex_tnew,  hz.id_rt_tuse) |
                    raw_hit(hz.id_rt_addr, hz.mem_wr_addr, hz.mem_tnew, hz.id_rt_tuse);
      md_stall    = hz.id_is_md & (md_busy_int | hz.ex_md_start);
      mem_stall   = hz.mem_req & ~hz.mem_ack;
      flush_any   = hz.flush_req | flush_pend;
   end

   // Priority arbitration: memory wait > flush > data/MDU stall > run.
   always_comb begin
      mode = MODE_RUN;
      if (!reset) begin
         mode = MODE_RESET;
      end else if (mem_stall) begin
         mode = MODE_MEM_WAIT;
      end else if (flush_any) begin
         mode = MODE_FLUSH;
      end else if (data_stall | md_stall) begin
         mode = MODE_STALL;
      end
   end

   // Stage control decode for the selected mode.
   always_comb begin
      pc_en_int     = 1'b1;
      hz.if_id_en   = 1'b1;
      hz.id_ex_en   = 1'b1;
      ex_mem_en_int = 1'b1;
      hz.mem_wb_en  = 1'b1;
      hz.if_id_clr  = 1'b0;
      hz.id_ex_clr  = 1'b0;
      hz.ex_mem_clr = 1'b0;
      hz.mem_wb_clr = 1'b0;
      unique case (mode)
         MODE_RESET: begin
            pc_en_int     = 1'b0;
            hz.if_id_en   = 1'b0;
            hz.id_ex_en   = 1'b0;
            ex_mem_en_int = 1'b0;
            hz.mem_wb_en  = 1'b0;
            hz.if_id_clr  = 1'b1;
            hz.id_ex_clr  = 1'b1;
            hz.ex_mem_clr = 1'b1;
            hz.mem_wb_clr = 1'b1;
         end
         MODE_MEM_WAIT: begin
            // Freeze upstream; WB gets a bubble so the held MEM op retires once.
            pc_en_int     = 1'b0;
            hz.if_id_en   = 1'b0;
            hz.id_ex_en   = 1'b0;
            ex_mem_en_int = 1'b0;
            hz.mem_wb_clr = 1'b1;
         end
         MODE_FLUSH: begin
            hz.if_id_clr  = 1'b1;
            hz.id_ex_clr  = 1'b1;
         end
         MODE_STALL: begin
            pc_en_int     = 1'b0;
            hz.if_id_en   = 1'b0;
            hz.id_ex_clr  = 1'b1;
         end
         default: begin
         end
      endcase
      hz.pc_en     = pc_en_int;
      hz.ex_mem_en = ex_mem_en_int;
      hz.md_busy   = md_busy_int;
   end

   // Next MDU count and pending-flush state.
   always_comb begin
      md_cnt_nxt     = md_cnt;
      flush_pend_nxt = 1'b0;
      if (hz.ex_md_start & ex_mem_en_int) begin
         md_cnt_nxt = hz.ex_md_is_div ? DIV_LD : MULT_LD;
      end else if (md_busy_int) begin
         md_cnt_nxt = md_cnt - CNT_W'(1);
      end
      if (mem_stall) begin
         flush_pend_nxt = flush_pend | hz.flush_req;
      end
   end

   // MDU busy counter and pending-flush latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt     <= '0;
         flush_pend <= 1'b0;
      end else begin
         md_cnt     <= md_cnt_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Performance counters: PC-frozen cycles and applied flushes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_en_int) begin
            stall_cycles <= stall_cycles + 32'(1);
         end
         if (mode == MODE_FLUSH) begin
            flush_count <= flush_count + 32'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

   // Expected control patterns: {pc_en, if_id/id_ex/ex_mem/mem_wb _en, same _clr}
   localparam logic [8:0] C_RUN   = 9'b1_1111_0000;
   localparam logic [8:0] C_STALL = 9'b0_0111_0100;
   localparam logic [8:0] C_FLUSH = 9'b1_1111_1100;
   localparam logic [8:0] C_MEMW  = 9'b0_0001_0001;
   localparam logic [8:0] C_RESET = 9'b0_0000_1111;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic [9:0] ctl;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   int          exp_stalls;
   int          exp_flushes;
`endif

   pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

   pipe_hazard_ctrl #(
      .REG_ADDR_W (5),
      .MULT_CYCLES(5),
      .DIV_CYCLES (10),
      .CNT_W      (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (hz)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ctl = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                 hz.if_id_clr, hz.id_ex_clr, hz.ex_mem_clr, hz.mem_wb_clr, hz.md_busy};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs are already set; check mid-cycle, then advance to 2 ns after the next edge.
   task automatic expect_cycle(input string tag, input logic [8:0] c, input logic busy);
      #3;
      check(tag, 32'(ctl), 32'({c, busy}));
`ifdef HAZ_PERF_CNT_EN
      check({tag, "_stallcnt"}, stall_cycles, 32'(exp_stalls));
      check({tag, "_flushcnt"}, flush_count, 32'(exp_flushes));
      if (!reset) begin
         exp_stalls  = 0;
         exp_flushes = 0;
      end else begin
         if (!c[8]) exp_stalls++;
         if (c == C_FLUSH) exp_flushes++;
      end
`endif
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      hz.id_rs_addr   = '0;
      hz.id_rt_addr   = '0;
      hz.id_rs_tuse   = 2'd3;
      hz.id_rt_tuse   = 2'd3;
      hz.id_is_md     = 1'b0;
      hz.ex_wr_addr   = '0;
      hz.ex_tnew      = 2'd0;
      hz.mem_wr_addr  = '0;
      hz.mem_tnew     = 2'd0;
      hz.ex_md_start  = 1'b0;
      hz.ex_md_is_div = 1'b0;
      hz.mem_req      = 1'b0;
      hz.mem_ack      = 1'b0;
      hz.flush_req    = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
`ifdef HAZ_PERF_CNT_EN
      exp_stalls  = 0;
      exp_flushes = 0;
`endif
      reset = 1'b0;
      idle_inputs();
      expect_cycle("reset_state", C_RESET, 1'b0);
      reset = 1'b1;
      expect_cycle("run_after_reset", C_RUN, 1'b0);

      // Load-use on rs from EX, then from MEM, then resolved.
      hz.id_rs_addr = 5'd8; hz.id_rs_tuse = 2'd0;
      hz.ex_wr_addr = 5'd8; hz.ex_tnew = 2'd2;
      expect_cycle("loaduse_ex", C_STALL, 1'b0);
      hz.ex_wr_addr = 5'd0; hz.ex_tnew = 2'd0;
      hz.mem_wr_addr = 5'd8; hz.mem_tnew = 2'd1;
      expect_cycle("loaduse_mem", C_STALL, 1'b0);
      hz.mem_tnew = 2'd0;
      expect_cycle("loaduse_resolved", C_RUN, 1'b0);

      // rt against EX: tnew <= tuse forwards, tnew > tuse stalls.
      idle_inputs();
      hz.id_rt_addr = 5'd9; hz.id_rt_tuse = 2'd1;
      hz.ex_wr_addr = 5'd9; hz.ex_tnew = 2'd1;
      expect_cycle("rt_tnew_eq_tuse", C_RUN, 1'b0);
      hz.id_rt_tuse = 2'd0;
      expect_cycle("rt_tnew_gt_tuse", C_STALL, 1'b0);

      // Register zero never hazards.
      idle_inputs();
      hz.id_rs_tuse = 2'd0; hz.ex_tnew = 2'd2; hz.mem_tnew = 2'd2;
      expect_cycle("zero_reg", C_RUN, 1'b0);

      // Divide: busy for 10 cycles, MDU consumer in ID stalls throughout.
      idle_inputs();
      hz.ex_md_start = 1'b1; hz.ex_md_is_div = 1'b1;
      expect_cycle("div_start", C_RUN, 1'b0);
      hz.ex_md_start = 1'b0; hz.ex_md_is_div = 1'b0; hz.id_is_md = 1'b1;
      for (int i = 1; i <= 10; i++) expect_cycle($sformatf("div_busy_%0d", i), C_STALL, 1'b1);
      expect_cycle("div_done", C_RUN, 1'b0);

      // Multiply with consumer already in ID at start: stalls 1 + 5 cycles.
      hz.ex_md_start = 1'b1;
      expect_cycle("mult_start", C_STALL, 1'b0);
      hz.ex_md_start = 1'b0;
      for (int i = 1; i <= 5; i++) expect_cycle($sformatf("mult_busy_%0d", i), C_STALL, 1'b1);
      expect_cycle("mult_done", C_RUN, 1'b0);

      // Memory wait of 3 cycles with a flush pulse in cycle 2.
      idle_inputs();
      hz.mem_req = 1'b1;
      expect_cycle("memw_1", C_MEMW, 1'b0);
      hz.flush_req = 1'b1;
      expect_cycle("memw_2_flush", C_MEMW, 1'b0);
      hz.flush_req = 1'b0;
      expect_cycle("memw_3", C_MEMW, 1'b0);
      hz.mem_req = 1'b0;
      expect_cycle("memw_flush_applied", C_FLUSH, 1'b0);
      expect_cycle("memw_pend_cleared", C_RUN, 1'b0);

      // Merge: flush while pending and again on release gives one flush.
      hz.mem_req = 1'b1; hz.flush_req = 1'b1;
      expect_cycle("merge_1", C_MEMW, 1'b0);
      expect_cycle("merge_2", C_MEMW, 1'b0);
      hz.mem_req = 1'b0;
      expect_cycle("merge_apply", C_FLUSH, 1'b0);
      hz.flush_req = 1'b0;
      expect_cycle("merge_once", C_RUN, 1'b0);

      // Acked memory access is not a stall.
      hz.mem_req = 1'b1; hz.mem_ack = 1'b1;
      expect_cycle("mem_acked", C_RUN, 1'b0);

      // Flush beats data stall; memory wait beats both.
      idle_inputs();
      hz.id_rs_addr = 5'd8; hz.id_rs_tuse = 2'd0;
      hz.ex_wr_addr = 5'd8; hz.ex_tnew = 2'd2;
      hz.flush_req = 1'b1;
      expect_cycle("flush_over_stall", C_FLUSH, 1'b0);
      hz.flush_req = 1'b0;
      hz.mem_req = 1'b1;
      expect_cycle("memw_over_stall", C_MEMW, 1'b0);
      hz.mem_req = 1'b0;
      expect_cycle("stall_after_memw", C_STALL, 1'b0);

      // Reset mid-divide: busy drops immediately, then normal run.
      idle_inputs();
      hz.ex_md_start = 1'b1; hz.ex_md_is_div = 1'b1;
      expect_cycle("rst_div_start", C_RUN, 1'b0);
      hz.ex_md_start = 1'b0; hz.ex_md_is_div = 1'b0;
      for (int i = 1; i <= 4; i++) expect_cycle($sformatf("rst_div_busy_%0d", i), C_RUN, 1'b1);
      reset = 1'b0;
      expect_cycle("rst_mid_div", C_RESET, 1'b0);
      reset = 1'b1;
      expect_cycle("run_after_rst_mid_div", C_RUN, 1'b0);
      expect_cycle("still_idle", C_RUN, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
